// File: rtl/latch_ctrl_pkg.sv
// Shared types and defaults for the debounced latch-load controller.
package latch_ctrl_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
   localparam int unsigned WIDTH_DEF           = 4;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   function automatic logic is_wait_state(input state_t s);
      return (s == PRESS_WAIT) || (s == RELEASE_WAIT);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; 2 cycles of latency, no backpressure.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/latch_load_ctrl.sv
// Debounces a load button and issues a one-cycle enable with switch data to a D latch.
// SYNC_STAGE_EN inserts a 2-flop synchronizer on btn_raw (+2 cycles); all outputs are registered.
module latch_load_ctrl
   import latch_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH           = WIDTH_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_raw,
   input  logic [WIDTH-1:0] sw,
   output logic             enable,
   output logic [WIDTH-1:0] d_out,
   output logic             btn_level,
   output logic             busy
);

   localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic btn_s;

`ifdef SYNC_STAGE_EN
   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (btn_raw),
      .q_o   (btn_s)
   );
`else
   assign btn_s = btn_raw;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             enable_q, enable_d;
   logic [WIDTH-1:0] d_out_q, d_out_d;
   logic             btn_level_q, btn_level_d;
   logic             busy_q, busy_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         enable_q    <= 1'b0;
         d_out_q     <= '0;
         btn_level_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         enable_q    <= enable_d;
         d_out_q     <= d_out_d;
         btn_level_q <= btn_level_d;
         busy_q      <= busy_d;
      end
   end

   // The entry sample counts as the first stable sample, so a wait state
   // completes when the incremented count would reach DEBOUNCE_CYCLES-1.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      enable_d    = 1'b0;
      d_out_d     = d_out_q;
      btn_level_d = btn_level_q;
      cnt_inc     = cnt_q + CNT_W'(1);

      case (state_q)
         IDLE: begin
            if (btn_s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_inc == CNT_LAST) begin
               state_d     = PRESSED;
               cnt_d       = '0;
               enable_d    = 1'b1;
               d_out_d     = sw;
               btn_level_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (btn_s) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_inc == CNT_LAST) begin
               state_d     = IDLE;
               cnt_d       = '0;
               btn_level_d = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      busy_d = is_wait_state(state_d);
   end

   assign enable    = enable_q;
   assign d_out     = d_out_q;
   assign btn_level = btn_level_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_latch_load_ctrl.sv
// Bench for latch_load_ctrl (DEBOUNCE_CYCLES=4, WIDTH=4): directed scenarios plus random button activity.
module tb_latch_load_ctrl;

   localparam int W  = 4;
   localparam int DC = 4;
`ifdef SYNC_STAGE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         btn_raw;
   logic [W-1:0] sw;
   logic         enable;
   logic [W-1:0] d_out;
   logic         btn_level;
   logic         busy;

   always #5 clk = ~clk;

   latch_load_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_raw),
      .sw        (sw),
      .enable    (enable),
      .d_out     (d_out),
      .btn_level (btn_level),
      .busy      (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: the debounced level flips once DC consecutive samples disagree with it.
   bit           hist[$];
   bit           m_lvl;
   int           m_run;
   logic [W-1:0] m_dout;
   bit           m_en;

   int cyc       = 0;
   int en_seen   = 0;
   int falls     = 0;
   int first_en  = -1;
   bit lvl_prev  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      m_lvl  = 1'b0;
      m_run  = 0;
      m_dout = '0;
      m_en   = 1'b0;
   endtask

   task automatic tick();
      bit bs;
      @(posedge clk);
      hist.push_back(btn_raw);
      if (hist.size() > LAT + 1) void'(hist.pop_front());
      bs   = (hist.size() == LAT + 1) ? hist[0] : 1'b0;
      m_en = 1'b0;
      if (bs != m_lvl) begin
         m_run++;
         if (m_run == DC) begin
            m_lvl = bs;
            m_run = 0;
            if (bs) begin
               m_en   = 1'b1;
               m_dout = sw;
            end
         end
      end else begin
         m_run = 0;
      end
      cyc++;
      #1;
      if (enable === 1'b1) begin
         en_seen++;
         if (first_en < 0) first_en = cyc;
      end
      if (lvl_prev && btn_level === 1'b0) falls++;
      lvl_prev = (btn_level === 1'b1);
      chk("enable", {31'd0, enable}, {31'd0, m_en});
      chk("d_out", {28'd0, d_out}, {28'd0, m_dout});
      chk("btn_level", {31'd0, btn_level}, {31'd0, m_lvl});
      chk("busy", {31'd0, busy}, {31'd0, (m_run > 0)});
   endtask

   task automatic apply_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_enable", {31'd0, enable}, 32'd0);
      chk("rst_d_out", {28'd0, d_out}, 32'd0);
      chk("rst_btn_level", {31'd0, btn_level}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      model_reset();
      lvl_prev = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   task automatic run(input int n, input bit b);
      btn_raw = b;
      repeat (n) tick();
   endtask

   initial begin
      int e0;
      int k;
      int f0;
      int bounce[7];

      rst_n   = 1'b0;
      btn_raw = 1'b0;
      sw      = '0;
      model_reset();
      #3;
      chk("init_enable", {31'd0, enable}, 32'd0);
      chk("init_d_out", {28'd0, d_out}, 32'd0);
      chk("init_btn_level", {31'd0, btn_level}, 32'd0);
      chk("init_busy", {31'd0, busy}, 32'd0);
      #4 rst_n = 1'b1;
      run(3, 1'b0);

      // Clean press
      sw = 4'hA;
      e0 = en_seen;
      first_en = -1;
      k = cyc + 1;
      btn_raw = 1'b1;
      for (int i = 0; i < 20 && first_en < 0; i++) tick();
      chk("press_latency", first_en, k + DC - 1 + LAT);
      chk("press_d_out", {28'd0, d_out}, 32'hA);
      chk("press_level", {31'd0, btn_level}, 32'd1);
      run(3, 1'b1);
      chk("press_enables", en_seen - e0, 32'd1);
      run(DC + LAT + 2, 1'b0);
      chk("release_level", {31'd0, btn_level}, 32'd0);

      // Press bounce: 1,1,0,1,1,1,1
      bounce = '{1, 1, 0, 1, 1, 1, 1};
      sw = 4'h6;
      e0 = en_seen;
      first_en = -1;
      k = cyc + 1;
      foreach (bounce[i]) run(1, bounce[i][0]);
      run(LAT + 2, 1'b1);
      chk("bounce_enable_at", first_en, k + 6 + LAT);
      chk("bounce_enables", en_seen - e0, 32'd1);
      chk("bounce_d_out", {28'd0, d_out}, 32'h6);

      // Release bounce: 0,0,1,0,0,0,0
      bounce = '{0, 0, 1, 0, 0, 0, 0};
      e0 = en_seen;
      f0 = falls;
      foreach (bounce[i]) run(1, bounce[i][0]);
      run(LAT + 2, 1'b0);
      chk("rel_bounce_enables", en_seen - e0, 32'd0);
      chk("rel_bounce_falls", falls - f0, 32'd1);
      chk("rel_bounce_level", {31'd0, btn_level}, 32'd0);

      // Reset while PRESS_WAIT holds cnt=2, button kept down through reset
      sw = 4'h5;
      e0 = en_seen;
      run(LAT + 3, 1'b1);
      chk("midcount_busy", {31'd0, busy}, 32'd1);
      apply_reset();
      chk("midcount_no_enable", en_seen - e0, 32'd0);
      first_en = -1;
      k = cyc + 1;
      for (int i = 0; i < 20 && first_en < 0; i++) tick();
      chk("after_reset_latency", first_en, k + DC - 1 + LAT);
      chk("after_reset_d_out", {28'd0, d_out}, 32'h5);
      run(DC + LAT + 2, 1'b0);

      // Long hold with switches changing mid-hold
      sw = 4'hC;
      e0 = en_seen;
      btn_raw = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (i == 50) sw = 4'h3;
         tick();
      end
      chk("hold_enables", en_seen - e0, 32'd1);
      chk("hold_d_out", {28'd0, d_out}, 32'hC);
      run(DC + LAT + 2, 1'b0);

      // Random bouncy activity with occasional resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 4) == 0) btn_raw = ~btn_raw;
         sw = W'($urandom);
         if ($urandom_range(0, 199) == 0) apply_reset();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
